// File: rtl/regfile_mp_sb.sv
// Parametrised multi-read-port register file with a sequential clear engine and
// a per-register pending scoreboard for decode/issue hazard detection.
module regfile_mp_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear_req,
  output logic                       ready,
  input  logic [NUM_RD*ADDR_W-1:0]   ra,
  output logic [NUM_RD*DATA_W-1:0]   rd,
  output logic [NUM_RD-1:0]          rd_pend,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          wa,
  input  logic [DATA_W-1:0]          wd,
  input  logic                       sb_set,
  input  logic [ADDR_W-1:0]          sb_addr
);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     clr_ptr_q, clr_ptr_d;
  logic                  ready_q, ready_d;
  logic [NUM_REGS-1:0]   pend_q, pend_d;
  logic [DATA_W-1:0]     mem_q [NUM_REGS];

  logic run;
  logic wr_valid;
  logic sb_valid;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < NUM_REGS;
  endfunction

  // Addresses that may hold state: in range and not the hardwired zero register.
  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return in_range(a) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign run      = (state_q == StRun);
  assign wr_valid = run && we && !clear_req && writable(wa);
  assign sb_valid = run && sb_set && !clear_req && writable(sb_addr);
  assign ready    = ready_q;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    ready_d   = ready_q;
    pend_d    = pend_q;
    case (state_q)
      StClear: begin
        pend_d    = '0;
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == ADDR_W'(NUM_REGS - 1)) begin
          state_d   = StRun;
          ready_d   = 1'b1;
          clr_ptr_d = '0;
        end
      end
      StRun: begin
        if (clear_req) begin
          state_d   = StClear;
          clr_ptr_d = '0;
          ready_d   = 1'b0;
          pend_d    = '0;
        end else begin
          if (wr_valid) pend_d[wa] = 1'b0;
          // A new producer issued in the same cycle outranks the retiring write.
          if (sb_valid) pend_d[sb_addr] = 1'b1;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StClear;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
      pend_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= ready_d;
      pend_q    <= pend_d;
    end
  end

  // Array has no reset; the clear sweep zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      mem_q[clr_ptr_q] <= '0;
    end else if (wr_valid) begin
      mem_q[wa] <= wd;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              hit;
    logic              live;

    assign a    = ra[k*ADDR_W +: ADDR_W];
    assign hit  = (BYPASS != 0) && wr_valid && (wa == a);
    assign live = run && writable(a);

    assign rd[k*DATA_W +: DATA_W] = !live ? '0 : (hit ? wd : mem_q[a]);
    assign rd_pend[k] = run && in_range(a) && (a != '0) && !hit && pend_q[a];
  end

endmodule
